milspi_packet_parser: RTL and testbench

Receive-side framer for the SPI packet protocol. Consumes the 16-bit word stream delivered by the SPI slave and splits it into address, size/command, data, checksum and packet-number fields. Filters packets by block address and validates the 16-bit additive checksum. It hands the header, the data words and a per-packet verdict to the command dispatcher inside the MIL-SPI bridge.

---
 rtl/milspi_packet_parser.sv | 187 ++++++++++++++++++
 tb/tb_milspi_packet_parser.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/milspi_packet_parser.sv
// Receive-side framer for the MIL-SPI bridge: splits the SPI word stream
// into header, data, checksum and packet-number fields.
module milspi_packet_parser #(
  parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
  parameter logic [15:0] TIMEOUT    = 16'd2000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_cmd,
  output logic [7:0]  hdr_size,
  output logic        data_valid,
  output logic [15:0] data_word,
  output logic [7:0]  data_index,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [1:0]  pkt_err,
  output logic [15:0] pkt_num,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    NUM
  } state_t;

  state_t      state, state_n;
  logic        match, match_n;
  logic [15:0] sum, sum_n;
  logic [7:0]  size, size_n;
  logic [7:0]  count, count_n;
  logic        csum_ok, csum_ok_n;
  logic [15:0] tmr, tmr_n;

  logic        hdr_valid_n;
  logic [7:0]  hdr_cmd_n;
  logic [7:0]  hdr_size_n;
  logic        data_valid_n;
  logic [15:0] data_word_n;
  logic [7:0]  data_index_n;
  logic        pkt_done_n;
  logic        pkt_ok_n;
  logic [1:0]  pkt_err_n;
  logic [15:0] pkt_num_n;

  logic        expire;
  logic        start_word;

  // Fires on the idle cycle in which the counter would reach TIMEOUT.
  assign expire = (state != IDLE) && !in_valid
               && (tmr == TIMEOUT - 16'd1);

  assign start_word = (in_data[7:0] == 8'h00)
                   && (in_data[15:8] != 8'h00);

  assign busy = (state != IDLE);

  always_comb begin
    state_n      = state;
    match_n      = match;
    sum_n        = sum;
    size_n       = size;
    count_n      = count;
    csum_ok_n    = csum_ok;
    tmr_n        = tmr;
    hdr_valid_n  = 1'b0;
    hdr_cmd_n    = hdr_cmd;
    hdr_size_n   = hdr_size;
    data_valid_n = 1'b0;
    data_word_n  = data_word;
    data_index_n = data_index;
    pkt_done_n   = 1'b0;
    pkt_ok_n     = pkt_ok;
    pkt_err_n    = pkt_err;
    pkt_num_n    = pkt_num;

    if (state == IDLE || in_valid) begin
      tmr_n = '0;
    end else begin
      tmr_n = tmr + 16'd1;
    end

    if (expire) begin
      state_n = IDLE;
      tmr_n   = '0;
      if (match) begin
        pkt_done_n = 1'b1;
        pkt_ok_n   = 1'b0;
        pkt_err_n  = 2'd2;
        pkt_num_n  = '0;
      end
    end else if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (start_word) begin
            match_n = (in_data[15:8] == BLOCK_ADDR);
            sum_n   = in_data;
            state_n = HDR;
          end
        end
        HDR: begin
          size_n  = in_data[15:8];
          sum_n   = sum + in_data;
          count_n = '0;
          if (match) begin
            hdr_valid_n = 1'b1;
            hdr_cmd_n   = in_data[7:0];
            hdr_size_n  = in_data[15:8];
          end
          state_n = (in_data[15:8] != 8'h00) ? DATA : CSUM;
        end
        DATA: begin
          sum_n   = sum + in_data;
          count_n = count + 8'd1;
          if (match) begin
            data_valid_n = 1'b1;
            data_word_n  = in_data;
            data_index_n = count;
          end
          if (count == size - 8'd1) begin
            state_n = CSUM;
          end
        end
        CSUM: begin
          csum_ok_n = (in_data == sum);
          state_n   = NUM;
        end
        NUM: begin
          if (match) begin
            pkt_done_n = 1'b1;
            pkt_ok_n   = csum_ok;
            pkt_err_n  = csum_ok ? 2'd0 : 2'd1;
            pkt_num_n  = in_data;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state      <= IDLE;
      match      <= 1'b0;
      sum        <= '0;
      size       <= '0;
      count      <= '0;
      csum_ok    <= 1'b0;
      tmr        <= '0;
      hdr_valid  <= 1'b0;
      hdr_cmd    <= '0;
      hdr_size   <= '0;
      data_valid <= 1'b0;
      data_word  <= '0;
      data_index <= '0;
      pkt_done   <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_err    <= '0;
      pkt_num    <= '0;
    end else begin
      state      <= state_n;
      match      <= match_n;
      sum        <= sum_n;
      size       <= size_n;
      count      <= count_n;
      csum_ok    <= csum_ok_n;
      tmr        <= tmr_n;
      hdr_valid  <= hdr_valid_n;
      hdr_cmd    <= hdr_cmd_n;
      hdr_size   <= hdr_size_n;
      data_valid <= data_valid_n;
      data_word  <= data_word_n;
      data_index <= data_index_n;
      pkt_done   <= pkt_done_n;
      pkt_ok     <= pkt_ok_n;
      pkt_err    <= pkt_err_n;
      pkt_num    <= pkt_num_n;
    end
  end

endmodule

// File: tb/tb_milspi_packet_parser.sv
// Scoreboard bench for milspi_packet_parser: expected header/data/done
// events are queued at stimulus time and matched against observed pulses.
module tb_milspi_packet_parser;

  localparam logic [15:0] TMO = 16'd20;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        hdr_valid;
  logic [7:0]  hdr_cmd;
  logic [7:0]  hdr_size;
  logic        data_valid;
  logic [15:0] data_word;
  logic [7:0]  data_index;
  logic        pkt_done;
  logic        pkt_ok;
  logic [1:0]  pkt_err;
  logic [15:0] pkt_num;
  logic        busy;

  int pass = 0;
  int total = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } ev_t;

  ev_t expq[$];
  ev_t obsq[$];

  milspi_packet_parser #(
    .BLOCK_ADDR(8'hAB),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .in_valid(in_valid),
    .in_data(in_data),
    .hdr_valid(hdr_valid),
    .hdr_cmd(hdr_cmd),
    .hdr_size(hdr_size),
    .data_valid(data_valid),
    .data_word(data_word),
    .data_index(data_index),
    .pkt_done(pkt_done),
    .pkt_ok(pkt_ok),
    .pkt_err(pkt_err),
    .pkt_num(pkt_num),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (hdr_valid)
      obsq.push_back({2'd1, 8'h00, hdr_cmd, 8'h00, hdr_size, 16'h0});
    if (data_valid)
      obsq.push_back({2'd2, data_word, 8'h00, data_index, 16'h0});
    if (pkt_done)
      obsq.push_back({2'd3, 15'h0, pkt_ok, 14'h0, pkt_err, pkt_num});
  end

  function automatic void exp_hdr(input logic [7:0] cmd,
                                  input logic [7:0] size);
    expq.push_back({2'd1, 8'h00, cmd, 8'h00, size, 16'h0});
  endfunction

  function automatic void exp_data(input logic [15:0] w,
                                   input logic [7:0] idx);
    expq.push_back({2'd2, w, 8'h00, idx, 16'h0});
  endfunction

  function automatic void exp_done(input logic ok,
                                   input logic [1:0] err,
                                   input logic [15:0] num);
    expq.push_back({2'd3, 15'h0, ok, 14'h0, err, num});
  endfunction

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    total++;
    if ({hdr_valid, data_valid, pkt_done} !== 3'b000)
      $display("FAIL reset_pulses got %b want 000",
               {hdr_valid, data_valid, pkt_done});
    else pass++;
    total++;
    if ({hdr_cmd, hdr_size, data_word, data_index} !== 40'h0)
      $display("FAIL reset_hdr_data got %h want 0",
               {hdr_cmd, hdr_size, data_word, data_index});
    else pass++;
    total++;
    if ({pkt_ok, pkt_err, pkt_num} !== 19'h0)
      $display("FAIL reset_pkt got %h want 0", {pkt_ok, pkt_err, pkt_num});
    else pass++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else pass++;
    obsq.delete();
  endtask

  task automatic test_status();
    exp_hdr(8'hB0, 8'h00);
    exp_done(1'b1, 2'd0, 16'h0001);
    send(16'h0000);
    send(16'hAB00);
    send(16'h00B0);
    send(16'hABB0);
    send(16'h0001);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL status missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL status event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL status extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_data_back_to_back();
    logic [15:0] words [12] = '{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001,
                                16'hFFA3, 16'h0002, 16'hFFA3, 16'hAB45,
                                16'hFFA3, 16'hFFA1, 16'h5D15, 16'h0000};
    exp_hdr(8'hA2, 8'h08);
    for (int i = 0; i < 8; i++) exp_data(words[i+2], 8'(i));
    exp_done(1'b1, 2'd0, 16'h0000);
    for (int i = 0; i < 12; i++) send(words[i]);
    // second status packet immediately after, no gap
    exp_hdr(8'hB0, 8'h00);
    exp_done(1'b1, 2'd0, 16'h0042);
    send(16'hAB00);
    send(16'h00B0);
    send(16'hABB0);
    send(16'h0042);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL data missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL data event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL data extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_bad_checksum();
    exp_hdr(8'hB0, 8'h00);
    exp_done(1'b0, 2'd1, 16'h0000);
    send(16'hAB00);
    send(16'h00B0);
    send(16'hB5B0);
    send(16'h0000);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL badsum missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL badsum event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL badsum extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_foreign();
    send(16'h0100);
    send(16'h00A0);
    send(16'h01A0);
    send(16'h0000);
    exp_hdr(8'hA0, 8'h00);
    exp_done(1'b1, 2'd0, 16'h0000);
    send(16'hAB00);
    send(16'h00A0);
    send(16'hABA0);
    send(16'h0000);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL foreign missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL foreign event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL foreign extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_timeout();
    int k = 0;
    exp_hdr(8'hB0, 8'h02);
    exp_data(16'h1234, 8'd0);
    exp_done(1'b0, 2'd2, 16'h0000);
    send(16'hAB00);
    send(16'h02B0);
    send(16'h1234);
    while (k < int'(TMO) + 5 && !pkt_done) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k < int'(TMO) - 1 || k > int'(TMO) + 1)
      $display("FAIL timeout_latency got %0d want %0d..%0d",
               k, TMO - 1, TMO + 1);
    else pass++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", busy);
    else pass++;
    repeat (2) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL timeout missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL timeout event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL timeout extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_timeout_edge();
    // next word lands on the very cycle the counter would expire
    exp_hdr(8'hB0, 8'h00);
    exp_done(1'b1, 2'd0, 16'h0003);
    send(16'hAB00);
    repeat (int'(TMO) - 1) @(negedge clk);
    send(16'h00B0);
    send(16'hABB0);
    send(16'h0003);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL tmo_edge missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL tmo_edge event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL tmo_edge extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_reset_mid();
    exp_hdr(8'hB2, 8'h04);
    exp_data(16'h1111, 8'd0);
    send(16'hAB00);
    send(16'h04B2);
    send(16'h1111);
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    total++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy);
    else pass++;
    exp_hdr(8'hB0, 8'h00);
    exp_done(1'b1, 2'd0, 16'h0007);
    send(16'hAB00);
    send(16'h00B0);
    send(16'hABB0);
    send(16'h0007);
    repeat (int'(TMO) + 4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL rstmid missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL rstmid event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL rstmid extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  task automatic test_size_255();
    logic [15:0] s = 16'hAB00 + 16'hFFC1;
    exp_hdr(8'hC1, 8'hFF);
    send(16'hAB00);
    send(16'hFFC1);
    for (int i = 0; i < 255; i++) begin
      logic [15:0] w = 16'(i * 257 + 3);
      exp_data(w, 8'(i));
      s = s + w;
      send(w);
    end
    exp_done(1'b1, 2'd0, 16'h00FF);
    send(s);
    send(16'h00FF);
    repeat (4) @(negedge clk);
    while (expq.size() != 0) begin
      ev_t e = expq.pop_front();
      total++;
      if (obsq.size() == 0) begin
        $display("FAIL size255 missing event got none want %h", e);
      end else begin
        ev_t o = obsq.pop_front();
        if (o !== e) $display("FAIL size255 event got %h want %h", o, e);
        else pass++;
      end
    end
    total++;
    if (obsq.size() != 0)
      $display("FAIL size255 extra events got %0d want 0", obsq.size());
    else pass++;
    obsq.delete();
  endtask

  initial begin
    test_reset();
    test_status();
    test_data_back_to_back();
    test_bad_checksum();
    test_foreign();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_size_255();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
